// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of the single-clock FIFO: write/read requests, read data and status flags.
interface sync_fifo_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO, any depth >= 2; read data 1 cycle after rd_en (or show-ahead).
// Backpressure via full/empty: writes when full and reads when empty are dropped and flagged.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int SHOW_AHEAD = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LO    = CNT_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_HI    = CNT_W'(AE_MARGIN);

  generate
    if (FIFO_DEPTH < 2 || AF_MARGIN < 1 || AF_MARGIN > FIFO_DEPTH - 1 ||
        AE_MARGIN < 1 || AE_MARGIN > FIFO_DEPTH - 1) begin : g_bad_param
      $error("sync_fifo_param: illegal FIFO_DEPTH or margin parameter");
    end
  endgenerate

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
      if (w_wr_acc) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= f_next(r_rd_ptr);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc && !bus.flush) r_mem[r_wr_ptr] <= bus.data_in;
  end

  generate
    if (SHOW_AHEAD == 0) begin : g_reg_out
      logic [FIFO_WIDTH-1:0] r_dout;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_dout <= '0;
        else if (w_rd_acc && !bus.flush)  r_dout <= r_mem[r_rd_ptr];
      end
      assign bus.data_out = r_dout;
    end else begin : g_show_ahead
      assign bus.data_out = r_mem[r_rd_ptr];
    end
  endgenerate

  assign bus.wr_ack      = r_wr_ack;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almostfull  = (r_count >= AF_LO) && !w_full;
  assign bus.almostempty = !w_empty && (r_count <= AE_HI);
  assign bus.count       = r_count;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param over three configurations.
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(16), .DEPTH(8)) if0 ();
  sync_fifo_param_if #(.WIDTH(16), .DEPTH(8)) if1 ();
  sync_fifo_param_if #(.WIDTH(16), .DEPTH(6)) if2 ();

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .SHOW_AHEAD(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(2), .AE_MARGIN(2), .SHOW_AHEAD(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_MARGIN(1), .AE_MARGIN(1), .SHOW_AHEAD(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int n_chk = 0;
  int n_err = 0;
  int m_cnt [3];
  logic [15:0] m_dout [3];
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];
  logic [15:0] sb2 [$];

  function automatic int dep(input int s);
    return (s == 2) ? 6 : 8;
  endfunction
  function automatic int afm(input int s);
    return (s == 1) ? 2 : 1;
  endfunction
  function automatic int aem(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int s, input logic [15:0] d);
    case (s)
      0: sb0.push_back(d);
      1: sb1.push_back(d);
      default: sb2.push_back(d);
    endcase
  endtask

  task automatic sb_pop(input int s, output logic [15:0] d);
    case (s)
      0: d = sb0.pop_front();
      1: d = sb1.pop_front();
      default: d = sb2.pop_front();
    endcase
  endtask

  task automatic sb_front(input int s, output logic [15:0] d);
    case (s)
      0: d = sb0[0];
      1: d = sb1[0];
      default: d = sb2[0];
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = 0;
      m_dout[k] = 16'h0;
    end
    sb0.delete();
    sb1.delete();
    sb2.delete();
  endtask

  task automatic drive(input int s, input logic w, input logic r, input logic fl, input logic [15:0] d);
    if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.flush = 1'b0; if0.data_in = 16'h0;
    if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.flush = 1'b0; if1.data_in = 16'h0;
    if2.wr_en = 1'b0; if2.rd_en = 1'b0; if2.flush = 1'b0; if2.data_in = 16'h0;
    case (s)
      0: begin if0.wr_en = w; if0.rd_en = r; if0.flush = fl; if0.data_in = d; end
      1: begin if1.wr_en = w; if1.rd_en = r; if1.flush = fl; if1.data_in = d; end
      2: begin if2.wr_en = w; if2.rd_en = r; if2.flush = fl; if2.data_in = d; end
      default: ;
    endcase
  endtask

  // flags = {full, empty, almostfull, almostempty, wr_ack, overflow, underflow}
  task automatic observe(input int s, output int c, output logic [6:0] f, output logic [15:0] d);
    case (s)
      0: begin
        c = int'(if0.count); d = if0.data_out;
        f = {if0.full, if0.empty, if0.almostfull, if0.almostempty, if0.wr_ack, if0.overflow, if0.underflow};
      end
      1: begin
        c = int'(if1.count); d = if1.data_out;
        f = {if1.full, if1.empty, if1.almostfull, if1.almostempty, if1.wr_ack, if1.overflow, if1.underflow};
      end
      default: begin
        c = int'(if2.count); d = if2.data_out;
        f = {if2.full, if2.empty, if2.almostfull, if2.almostempty, if2.wr_ack, if2.overflow, if2.underflow};
      end
    endcase
  endtask

  task automatic check_reset(input int s);
    int c;
    logic [6:0] f;
    logic [15:0] d;
    observe(s, c, f, d);
    chk($sformatf("d%0d_rst_count", s), c, 0);
    chk($sformatf("d%0d_rst_flags", s), f, 7'b0100000);
    if (s != 1) chk($sformatf("d%0d_rst_dout", s), d, 16'h0);
  endtask

  // One clock on DUT s; bench model predicts every output after the edge.
  task automatic cyc(input int s, input logic w, input logic r, input logic fl, input logic [15:0] d);
    logic wacc, racc;
    logic [15:0] pd, hd, od;
    logic [6:0] f;
    int oc, dd, n;
    dd   = dep(s);
    wacc = w && (m_cnt[s] != dd);
    racc = r && (m_cnt[s] != 0);
    drive(s, w, r, fl, d);
    @(posedge clk);
    #1;
    if (fl) begin
      for (int k = 0; k < m_cnt[s]; k++) sb_pop(s, pd);
      m_cnt[s] = 0;
    end else begin
      if (wacc) sb_push(s, d);
      if (racc) begin
        sb_pop(s, pd);
        if (s != 1) m_dout[s] = pd;
      end
      m_cnt[s] = m_cnt[s] + (wacc ? 1 : 0) - (racc ? 1 : 0);
    end
    n = m_cnt[s];
    observe(s, oc, f, od);
    chk($sformatf("d%0d_count", s), oc, n);
    chk($sformatf("d%0d_full", s), f[6], n == dd);
    chk($sformatf("d%0d_empty", s), f[5], n == 0);
    chk($sformatf("d%0d_almostfull", s), f[4], (n >= dd - afm(s)) && (n < dd));
    chk($sformatf("d%0d_almostempty", s), f[3], (n >= 1) && (n <= aem(s)));
    chk($sformatf("d%0d_wr_ack", s), f[2], !fl && wacc);
    chk($sformatf("d%0d_overflow", s), f[1], !fl && w && !wacc);
    chk($sformatf("d%0d_underflow", s), f[0], !fl && r && !racc);
    if (s != 1) chk($sformatf("d%0d_dout", s), od, m_dout[s]);
    else if (n != 0) begin
      sb_front(1, hd);
      chk("d1_head", od, hd);
    end
    @(negedge clk);
  endtask

  initial begin
    int c;
    logic [6:0] f;
    logic [15:0] d;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    model_reset();
    #1;
    check_reset(0);
    check_reset(1);
    check_reset(2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill to full: almostfull at 7, full (not almostfull) at 8.
    for (int i = 1; i <= 8; i++) cyc(0, 1'b1, 1'b0, 1'b0, 16'(i));
    observe(0, c, f, d);
    chk("fill_count8", c, 8);
    chk("fill_full_not_af", {f[6], f[4]}, 2'b10);

    // Overflow, then write+read while full.
    cyc(0, 1'b1, 1'b0, 1'b0, 16'h0009);
    cyc(0, 1'b1, 1'b1, 1'b0, 16'h000A);
    observe(0, c, f, d);
    chk("full_rw_dout", d, 16'h0001);
    chk("full_rw_overflow", f[1], 1'b1);
    for (int i = 0; i < 7; i++) cyc(0, 1'b0, 1'b1, 1'b0, 16'h0);

    // Read on empty with simultaneous write.
    cyc(0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    observe(0, c, f, d);
    chk("empty_rw_underflow", f[0], 1'b1);
    chk("empty_rw_count", c, 1);
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0);
    observe(0, c, f, d);
    chk("beef_dout", d, 16'hBEEF);

    // Depth 6: interleaved traffic wraps both pointers several times.
    for (int i = 0; i < 20; i++)
      cyc(2, (i % 4) != 3, (i % 2) == 1, 1'b0, 16'h0100 + 16'(i));
    for (int i = 0; i < 4; i++) cyc(2, 1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i));
    for (int i = 0; i < 8; i++) cyc(2, 1'b0, 1'b1, 1'b0, 16'h0);

    // Show-ahead with margins of 2.
    cyc(1, 1'b1, 1'b0, 1'b0, 16'hA5A5);
    observe(1, c, f, d);
    chk("sa_first_dout", d, 16'hA5A5);
    for (int i = 1; i < 8; i++) cyc(1, 1'b1, 1'b0, 1'b0, 16'hA500 + 16'(i));
    for (int i = 0; i < 8; i++) cyc(1, 1'b0, 1'b1, 1'b0, 16'h0);

    // Flush with a concurrent write at count 5.
    for (int i = 0; i < 5; i++) cyc(0, 1'b1, 1'b0, 1'b0, 16'h0300 + 16'(i));
    cyc(0, 1'b1, 1'b0, 1'b1, 16'h0055);
    observe(0, c, f, d);
    chk("flush_count", c, 0);
    chk("flush_wr_ack", f[2], 1'b0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 1'b0, 16'h0400 + 16'(i));
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0499);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset(0);
    check_reset(2);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1'b1, 1'b0, 1'b0, 16'h7777);
    cyc(0, 1'b1, 1'b0, 1'b0, 16'h8888);
    cyc(0, 1'b0, 1'b1, 1'b0, 16'h0);
    observe(0, c, f, d);
    chk("post_rst_dout", d, 16'h7777);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
